// File: rtl/pc_sequencer.sv
// Fetch/execute sequencer driving the PC register load path, the instruction
// fetch handshake and the retired-instruction counter.
module pc_sequencer #(
  parameter logic [31:0] RESET_PC   = 32'h0040_0000,
  parameter logic [31:0] EXC_VECTOR = 32'h8000_0180,
  parameter logic [31:0] PC_INC     = 32'd4
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] pc_cur,
  output logic [31:0] pc_next,
  output logic        pc_ld,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_ack,
  input  logic [31:0] imem_rdata,
  output logic [31:0] instr,
  output logic        instr_valid,
  input  logic        exec_done,
  input  logic        br_taken,
  input  logic [31:0] br_target,
  input  logic        exc_req,
  input  logic        stall,
  output logic        misalign_exc,
  output logic [31:0] retire_cnt
);

  typedef enum logic [1:0] {
    S_RST_LOAD,
    S_FETCH,
    S_EXEC,
    S_UPDATE
  } state_t;

  state_t      r_state;
  logic [31:0] r_pc_next;
  logic        r_pc_ld;
  logic        r_imem_req;
  logic [31:0] r_imem_addr;
  logic [31:0] r_instr;
  logic        r_instr_valid;
  logic        r_misalign;
  logic [31:0] r_retire;
  logic        r_exc_pend;
  logic [31:0] r_target;

  logic [31:0] w_seq_pc;
  logic        w_misaligned;

  assign w_seq_pc     = pc_cur + PC_INC;
  assign w_misaligned = br_target[1:0] != 2'b00;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state       <= S_RST_LOAD;
      r_pc_next     <= RESET_PC;
      r_pc_ld       <= 1'b0;
      r_imem_req    <= 1'b0;
      r_imem_addr   <= '0;
      r_instr       <= '0;
      r_instr_valid <= 1'b0;
      r_misalign    <= 1'b0;
      r_retire      <= '0;
      r_exc_pend    <= 1'b0;
      r_target      <= RESET_PC;
    end else begin
      r_pc_ld    <= 1'b0;
      r_misalign <= 1'b0;
      case (r_state)
        S_RST_LOAD: begin
          r_pc_next <= RESET_PC;
          r_pc_ld   <= 1'b1;
          r_state   <= S_FETCH;
        end
        S_FETCH: begin
          r_imem_req  <= 1'b1;
          r_imem_addr <= pc_cur;
          if (exc_req) r_exc_pend <= 1'b1;
          // An ack only completes a request that is already visible on imem_req.
          if (r_imem_req && imem_ack) begin
            r_imem_req <= 1'b0;
            if (r_exc_pend || exc_req) begin
              r_target <= EXC_VECTOR;
              r_state  <= S_UPDATE;
            end else begin
              r_instr       <= imem_rdata;
              r_instr_valid <= 1'b1;
              r_state       <= S_EXEC;
            end
          end
        end
        S_EXEC: begin
          if (exc_req) begin
            r_target      <= EXC_VECTOR;
            r_instr_valid <= 1'b0;
            r_state       <= S_UPDATE;
          end else if (exec_done) begin
            r_instr_valid <= 1'b0;
            r_state       <= S_UPDATE;
            if (br_taken && w_misaligned) begin
              r_target   <= EXC_VECTOR;
              r_misalign <= 1'b1;
            end else begin
              r_target <= br_taken ? br_target : w_seq_pc;
              r_retire <= r_retire + 32'd1;
            end
          end
        end
        S_UPDATE: begin
          if (!stall) begin
            r_pc_next  <= r_target;
            r_pc_ld    <= 1'b1;
            r_exc_pend <= 1'b0;
            r_state    <= S_FETCH;
          end
        end
      endcase
    end
  end

  assign pc_next      = r_pc_next;
  assign pc_ld        = r_pc_ld;
  assign imem_req     = r_imem_req;
  assign imem_addr    = r_imem_addr;
  assign instr        = r_instr;
  assign instr_valid  = r_instr_valid;
  assign misalign_exc = r_misalign;
  assign retire_cnt   = r_retire;

endmodule

// File: tb/tb_pc_sequencer.sv
// Randomized self-checking bench for pc_sequencer: a transaction-level model
// predicts each next PC, retire count and misalign pulse per instruction.
module tb_pc_sequencer;

  localparam logic [31:0] RESET_PC = 32'h0040_0000;
  localparam logic [31:0] EXC_VEC  = 32'h8000_0180;

  logic        clk = 1'b0;
  logic        rst;
  logic [31:0] pc_cur;
  logic [31:0] pc_next;
  logic        pc_ld;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_ack;
  logic [31:0] imem_rdata;
  logic [31:0] instr;
  logic        instr_valid;
  logic        exec_done;
  logic        br_taken;
  logic [31:0] br_target;
  logic        exc_req;
  logic        stall;
  logic        misalign_exc;
  logic [31:0] retire_cnt;

  pc_sequencer #(
    .RESET_PC  (RESET_PC),
    .EXC_VECTOR(EXC_VEC),
    .PC_INC    (32'd4)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .pc_cur      (pc_cur),
    .pc_next     (pc_next),
    .pc_ld       (pc_ld),
    .imem_req    (imem_req),
    .imem_addr   (imem_addr),
    .imem_ack    (imem_ack),
    .imem_rdata  (imem_rdata),
    .instr       (instr),
    .instr_valid (instr_valid),
    .exec_done   (exec_done),
    .br_taken    (br_taken),
    .br_target   (br_target),
    .exc_req     (exc_req),
    .stall       (stall),
    .misalign_exc(misalign_exc),
    .retire_cnt  (retire_cnt)
  );

  always #5 clk = ~clk;

  // PC register loading on the falling edge
  logic [31:0] pc_reg = '0;
  assign pc_cur = pc_reg;
  always @(negedge clk) if (pc_ld) pc_reg <= pc_next;

  int n_tests = 0;
  int n_fail  = 0;
  int n_ld    = 0;
  int ld_mark = 0;
  logic prev_ld = 1'b0;

  logic [31:0] m_pc;
  logic [31:0] m_ret;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  always @(negedge clk) begin
    if (!rst) chk("ld_back_to_back", 32'(pc_ld & prev_ld), 32'd0);
    prev_ld <= pc_ld;
    if (pc_ld) n_ld <= n_ld + 1;
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_req(output logic ok);
    ok = 1'b0;
    for (int i = 0; i < 20 && !ok; i++) begin
      if (imem_req) ok = 1'b1;
      else tick();
    end
    if (!ok) chk("req_timeout", 32'd0, 32'd1);
  endtask

  // fexc: 0 none, 1 exception pulse before ack, 2 exception with ack
  // ekind: 0 sequential, 1 taken branch, 2 exception, 3 exception with exec_done
  task automatic run_instr(input int fexc, input int ack_dly, input int ekind,
                           input logic [31:0] tgt, input int idle, input int stl);
    logic [31:0] word;
    logic [31:0] exp_t;
    logic        retire;
    logic        mis;
    logic        ok;
    int          dly;
    wait_req(ok);
    if (ok) begin
      chk("ld_count", 32'(n_ld - ld_mark), 32'd1);
      ld_mark = n_ld;
      chk("fetch_addr", imem_addr, m_pc);
      chk("valid_in_fetch", 32'(instr_valid), 32'd0);
      word   = $urandom;
      retire = 1'b0;
      mis    = 1'b0;
      dly    = (fexc == 1 && ack_dly == 0) ? 1 : ack_dly;
      for (int i = 0; i < dly; i++) begin
        if (fexc == 1 && i == 0) exc_req = 1'b1;
        tick();
        exc_req = 1'b0;
      end
      imem_ack   = 1'b1;
      imem_rdata = word;
      if (fexc == 2) exc_req = 1'b1;
      if (fexc != 0) stall = (stl > 0);
      tick();
      imem_ack   = 1'b0;
      exc_req    = 1'b0;
      imem_rdata = $urandom;
      if (fexc != 0) begin
        exp_t = EXC_VEC;
        chk("fexc_no_valid", 32'(instr_valid), 32'd0);
      end else begin
        chk("instr_valid", 32'(instr_valid), 32'd1);
        chk("instr", instr, word);
        for (int i = 0; i < idle; i++) begin
          tick();
          chk("valid_held", 32'(instr_valid), 32'd1);
        end
        case (ekind)
          0: begin exp_t = m_pc + 32'd4; retire = 1'b1; end
          1: begin
            if (tgt[1:0] != 2'b00) begin exp_t = EXC_VEC; mis = 1'b1; end
            else begin exp_t = tgt; retire = 1'b1; end
          end
          default: exp_t = EXC_VEC;
        endcase
        exec_done = (ekind != 2);
        br_taken  = (ekind == 1) || (ekind == 3);
        br_target = tgt;
        exc_req   = (ekind >= 2);
        stall     = (stl > 0);
        tick();
        exec_done = 1'b0;
        exc_req   = 1'b0;
        br_taken  = 1'b0;
        chk("misalign", 32'(misalign_exc), 32'(mis));
        chk("valid_clear", 32'(instr_valid), 32'd0);
      end
      if (retire) m_ret = m_ret + 32'd1;
      chk("retire_cnt", retire_cnt, m_ret);
      for (int i = 0; i < stl; i++) begin
        chk("ld_during_stall", 32'(pc_ld), 32'd0);
        if (i == 0) begin exec_done = 1'b1; br_taken = 1'b1; end
        tick();
        exec_done = 1'b0;
        br_taken  = 1'b0;
      end
      stall = 1'b0;
      chk("ld_before_update", 32'(pc_ld), 32'd0);
      tick();
      chk("ld_pulse", 32'(pc_ld), 32'd1);
      chk("pc_next", pc_next, exp_t);
      chk("misalign_one_cycle", 32'(misalign_exc), 32'd0);
      chk("retire_after", retire_cnt, m_ret);
      m_pc = exp_t;
    end
  endtask

  task automatic reset_mid_fetch(input int pre);
    logic ok;
    wait_req(ok);
    if (ok) begin
      chk("ld_count", 32'(n_ld - ld_mark), 32'd1);
      ld_mark = n_ld;
      for (int i = 0; i < pre; i++) tick();
      rst = 1'b1;
      tick();
      rst        = 1'b0;
      imem_ack   = 1'b1;
      imem_rdata = $urandom;
      tick();
      imem_ack = 1'b0;
      chk("rst_ld", 32'(pc_ld), 32'd1);
      chk("rst_pc_next", pc_next, RESET_PC);
      chk("rst_retire", retire_cnt, 32'd0);
      chk("rst_valid", 32'(instr_valid), 32'd0);
      chk("rst_req", 32'(imem_req), 32'd0);
      m_pc  = RESET_PC;
      m_ret = '0;
    end
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "simulation did not finish");
  end

  initial begin
    logic [31:0] t;
    int fx;
    int ad;
    int ek;
    rst = 1'b1;
    imem_ack = 1'b0; imem_rdata = '0;
    exec_done = 1'b0; br_taken = 1'b0; br_target = '0;
    exc_req = 1'b0; stall = 1'b0;
    m_pc = RESET_PC;
    m_ret = '0;
    repeat (3) tick();
    chk("rst_pc_ld", 32'(pc_ld), 32'd0);
    chk("rst_pc_next0", pc_next, RESET_PC);
    chk("rst_imem_req", 32'(imem_req), 32'd0);
    chk("rst_imem_addr", imem_addr, 32'd0);
    chk("rst_instr", instr, 32'd0);
    chk("rst_instr_valid", 32'(instr_valid), 32'd0);
    chk("rst_misalign", 32'(misalign_exc), 32'd0);
    chk("rst_retire0", retire_cnt, 32'd0);
    rst = 1'b0;
    tick();
    chk("init_ld", 32'(pc_ld), 32'd1);
    chk("init_pc_next", pc_next, RESET_PC);

    run_instr(0, 2, 0, 32'h0, 0, 0);
    run_instr(0, 0, 1, 32'h0040_0100, 1, 0);
    run_instr(0, 1, 1, 32'h0040_0102, 0, 0);
    run_instr(1, 2, 0, 32'h0, 0, 0);
    run_instr(2, 0, 1, 32'h0000_1000, 0, 2);
    run_instr(0, 0, 0, 32'h0, 0, 5);
    run_instr(0, 0, 2, 32'h0000_2000, 1, 0);
    run_instr(0, 1, 3, 32'h0000_3000, 0, 1);
    reset_mid_fetch(1);
    run_instr(0, 0, 1, 32'hFFFF_FFFC, 0, 0);
    run_instr(0, 1, 0, 32'h0, 0, 0);

    for (int n = 0; n < 200; n++) begin
      fx = ($urandom_range(0, 9) == 0) ? int'($urandom_range(1, 2)) : 0;
      ad = int'($urandom_range(0, 3));
      case ($urandom_range(0, 9))
        0, 1, 2, 3: ek = 0;
        4, 5, 6, 7: ek = 1;
        8:          ek = 2;
        default:    ek = 3;
      endcase
      t = $urandom;
      if ($urandom_range(0, 3) != 0) t[1:0] = 2'b00;
      run_instr(fx, ad, ek, t, int'($urandom_range(0, 2)),
                ($urandom_range(0, 1) == 0) ? 0 : int'($urandom_range(1, 4)));
      if (n == 100) reset_mid_fetch(int'($urandom_range(0, 2)));
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/pc_sequencer.md
Name: pc_sequencer

Overview:
- Multi-cycle fetch/execute sequencer that owns the program-counter register's load path.
- Drives next-PC value and load strobe, runs the instruction-memory fetch handshake, and holds each fetched instruction for execute.
- Selects next PC with fixed priority: exception > taken branch/jump > sequential.
- Counts retired instructions.

Parameters:
- RESET_PC, 32'h0040_0000, PC value loaded after reset.
- EXC_VECTOR, 32'h8000_0180, PC loaded on an exception or a misaligned target.
- PC_INC, 4, sequential increment in bytes.

Ports:
- clk  input  1  system clock; all logic on posedge.
- rst  input  1  synchronous, active-high reset.
- pc_cur  input  32  current PC, read back from the PC register output.
- pc_next  output  32  value for the PC register input.
- pc_ld  output  1  PC register load strobe; one-cycle pulse.
- imem_req  output  1  fetch request; held until acknowledged.
- imem_addr  output  32  fetch address.
- imem_ack  input  1  fetch complete; imem_rdata valid in the same cycle.
- imem_rdata  input  32  fetched word.
- instr  output  32  latched instruction for decode/execute.
- instr_valid  output  1  instr is valid and awaiting execute.
- exec_done  input  1  execute finished the current instruction; single-cycle pulse.
- br_taken  input  1  qualified by exec_done; redirect to br_target.
- br_target  input  32  branch/jump target.
- exc_req  input  1  exception request; sampled in FETCH and EXEC.
- stall  input  1  blocks the PC update while high.
- misalign_exc  output  1  one-cycle pulse when a taken target has bits [1:0] != 0.
- retire_cnt  output  32  instructions retired; wraps modulo 2^32.

Behaviour:
- All outputs registered. The PC register loads on negedge, so pc_next/pc_ld are stable across it, and pc_cur shows the new value at the next posedge.
- Reset values: state=RST_LOAD, pc_ld=0, pc_next=RESET_PC, imem_req=0, imem_addr=0, instr=0, instr_valid=0, misalign_exc=0, retire_cnt=0, exc_pend=0.
- Reset asserted in any state aborts the operation in flight. An outstanding fetch is abandoned and a late imem_ack is ignored.
- RST_LOAD:
  - pc_next=RESET_PC, pc_ld=1 for one cycle, then -> FETCH.
- FETCH:
  - imem_req=1, imem_addr=pc_cur.
  - exc_req sets exc_pend.
  - On imem_ack with exc_pend=0: instr<=imem_rdata, instr_valid<=1, imem_req<=0, -> EXEC.
  - On imem_ack with exc_pend=1 (or exc_req in the same cycle): word discarded, instr_valid stays 0, target=EXC_VECTOR, -> UPDATE.
- EXEC:
  - Wait for exec_done or exc_req.
  - exc_req has priority: target=EXC_VECTOR, no retire.
  - Else on exec_done with br_taken=1 and br_target[1:0]!=0: target=EXC_VECTOR, misalign_exc pulse, no retire.
  - Else on exec_done with br_taken=1: target=br_target, retire.
  - Else on exec_done: target=pc_cur+PC_INC (32-bit wrap, carry dropped), retire.
  - Retire: retire_cnt+1. instr_valid cleared on exit. -> UPDATE.
- UPDATE:
  - While stall=1: pc_ld=0 and target held.
  - First cycle with stall=0: pc_next=target, pc_ld=1 for exactly one cycle, exc_pend cleared, -> FETCH on the next cycle.
- pc_ld is never high for two consecutive cycles. It is high only in RST_LOAD and UPDATE.
- exc_req arriving while in UPDATE is ignored; the exception source holds it until FETCH.
- exec_done outside EXEC is ignored.
- PC wrap: pc_cur=32'hFFFF_FFFC sequential -> 32'h0000_0000.

Test Plan:
1. Reset release, imem_ack after 2 cycles, exec_done br_taken=0 -> pc_ld pulse with pc_next=0x00400000; fetch addr 0x00400000; second pc_next=0x00400004; retire_cnt=1.
2. exec_done with br_taken=1, br_target=0x00400100 -> pc_next=0x00400100, next imem_addr=0x00400100; with br_target=0x00400102 -> misalign_exc pulse, pc_next=0x80000180, retire_cnt unchanged.
3. exc_req pulse during FETCH before imem_ack -> instr_valid never rises, pc_next=0x80000180, single pc_ld.
4. stall held 5 cycles in UPDATE -> pc_ld low throughout, then one pulse with the held target; no double load.
5. rst asserted mid-FETCH with imem_ack arriving the cycle after -> ack ignored, retire_cnt=0, pc_next=0x00400000 reload.
6. pc_cur=0xFFFFFFFC sequential retire -> pc_next=0x00000000; retire_cnt preset path 0xFFFFFFFF -> 0x00000000.
